// File: rtl/camera_capture.sv
// camera_capture: OV7670 capture stage feeding the frame buffer.
// Packs RGB565 byte pairs into RGB332 and issues one write per stored pixel
// at address x + y*SCREEN_WIDTH, plus a frame-complete pulse on VSYNC rise.
module camera_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_WIDTH    = 15
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  VSYNC,
  input  logic                  HREF,
  input  logic [7:0]            CAM_DATA,
  output logic [7:0]            PIXEL_OUT,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic                  W_EN,
  output logic                  FRAME_DONE,
  output logic [7:0]            LINE_COUNT
);

  typedef enum logic [1:0] {
    WAIT_VS_HIGH,
    WAIT_VS_LOW,
    CAPTURE
  } state_t;

  localparam logic [9:0]            X_LIMIT    = 10'(SCREEN_WIDTH);
  localparam logic [9:0]            Y_LIMIT    = 10'(SCREEN_HEIGHT);
  localparam logic [9:0]            X_MAX      = 10'd1023;
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

  state_t                state, state_next;
  logic [9:0]            x, x_next;
  logic [9:0]            y, y_next;
  logic                  phase, phase_next;
  // Only the R[7:5] and G[2:0] bits of the first byte survive the packing
  logic [5:0]            byte1, byte1_next;
  logic                  href_q;
  logic [7:0]            pixel_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  wen_next;
  logic                  done_next;
  logic [7:0]            line_next;
  logic [ADDR_WIDTH-1:0] pix_addr;

  assign pix_addr = ADDR_WIDTH'(x) + ADDR_WIDTH'(y) * ROW_STRIDE;

  // Register the FSM state, counters, outputs and the delayed HREF used for line-end detection
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= WAIT_VS_HIGH;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      byte1      <= '0;
      href_q     <= 1'b0;
      PIXEL_OUT  <= '0;
      W_ADDR     <= '0;
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      LINE_COUNT <= '0;
    end else begin
      state      <= state_next;
      x          <= x_next;
      y          <= y_next;
      phase      <= phase_next;
      byte1      <= byte1_next;
      href_q     <= HREF;
      PIXEL_OUT  <= pixel_next;
      W_ADDR     <= addr_next;
      W_EN       <= wen_next;
      FRAME_DONE <= done_next;
      LINE_COUNT <= line_next;
    end
  end

  // Frame framing, pixel assembly and line bookkeeping; VSYNC outranks HREF in CAPTURE
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    phase_next = phase;
    byte1_next = byte1;
    pixel_next = PIXEL_OUT;
    addr_next  = W_ADDR;
    wen_next   = 1'b0;
    done_next  = 1'b0;
    line_next  = LINE_COUNT;
    case (state)
      WAIT_VS_HIGH: begin
        if (VSYNC) state_next = WAIT_VS_LOW;
      end
      WAIT_VS_LOW: begin
        if (!VSYNC) begin
          state_next = CAPTURE;
          x_next     = '0;
          y_next     = '0;
          phase_next = 1'b0;
          line_next  = '0;
        end
      end
      CAPTURE: begin
        if (VSYNC) begin
          done_next  = 1'b1;
          state_next = WAIT_VS_LOW;
        end else if (HREF) begin
          if (!phase) begin
            byte1_next = {CAM_DATA[7:5], CAM_DATA[2:0]};
            phase_next = 1'b1;
          end else begin
            phase_next = 1'b0;
            if (x != X_MAX) x_next = x + 10'd1;
            if ((x < X_LIMIT) && (y < Y_LIMIT)) begin
              wen_next   = 1'b1;
              addr_next  = pix_addr;
              pixel_next = {byte1, CAM_DATA[4:3]};
            end
          end
        end else if (href_q) begin
          x_next     = '0;
          phase_next = 1'b0;
          if (x != 10'd0) begin
            if (y < Y_LIMIT) y_next = y + 10'd1;
            if (LINE_COUNT != 8'hFF) line_next = LINE_COUNT + 8'd1;
          end
        end
      end
      default: state_next = WAIT_VS_HIGH;
    endcase
  end

endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: directed bench for camera_capture with a write scoreboard.
// Expected writes are queued as bytes are driven; a negedge monitor pops and
// compares them whenever W_EN is seen.
module tb_camera_capture;

  localparam int W  = 176;
  localparam int H  = 144;
  localparam int AW = 15;

  logic          CLOCK;
  logic          RESET;
  logic          VSYNC;
  logic          HREF;
  logic [7:0]    CAM_DATA;
  logic [7:0]    PIXEL_OUT;
  logic [AW-1:0] W_ADDR;
  logic          W_EN;
  logic          FRAME_DONE;
  logic [7:0]    LINE_COUNT;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    pix;
  } wr_t;

  wr_t           expQ[$];
  wr_t           popped;
  int            tests = 0;
  int            fails = 0;
  int            writeCount = 0;
  int            frameDoneCount = 0;
  logic [AW-1:0] lastAddr = '0;

  camera_capture #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_WIDTH   (AW)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .VSYNC     (VSYNC),
    .HREF      (HREF),
    .CAM_DATA  (CAM_DATA),
    .PIXEL_OUT (PIXEL_OUT),
    .W_ADDR    (W_ADDR),
    .W_EN      (W_EN),
    .FRAME_DONE(FRAME_DONE),
    .LINE_COUNT(LINE_COUNT)
  );

  // Free-running pixel clock
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Abort a run that somehow stops making progress
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of camera inputs and return just after the sampling edge
  task automatic applyStimulus(input logic vs, input logic href, input logic [7:0] data);
    VSYNC    = vs;
    HREF     = href;
    CAM_DATA = data;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic pushExpected(input int addr, input logic [7:0] pix);
    wr_t e;
    e.addr = AW'(addr);
    e.pix  = pix;
    expQ.push_back(e);
  endtask

  // One HREF line of npix pixels, optional dangling byte, then HREF low
  task automatic sendLine(input int y, input int npix, input bit oddByte, input bit expectWrites);
    logic [7:0] b1;
    logic [7:0] b2;
    for (int p = 0; p < npix; p++) begin
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      applyStimulus(1'b0, 1'b1, b1);
      if (expectWrites && p < W && y < H)
        pushExpected(p + y * W, {b1[7:5], b1[2:0], b2[4:3]});
      applyStimulus(1'b0, 1'b1, b2);
    end
    if (oddByte) applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic startFrame();
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic endFrame(input int expLines);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("frame_done_pulse", FRAME_DONE, 1);
    checkOutput("line_count", LINE_COUNT, expLines);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("frame_done_one_cycle", FRAME_DONE, 0);
  endtask

  // Scoreboard monitor: every observed write must match the oldest expectation
  always @(negedge CLOCK) begin
    if (FRAME_DONE === 1'b1) frameDoneCount++;
    if (W_EN === 1'b1) begin
      writeCount++;
      lastAddr = W_ADDR;
      tests++;
      assert (expQ.size() != 0) else begin
        fails++;
        $error("[TB] FAIL unexpected_write: observed write at addr %0d, expected none", W_ADDR);
      end
      if (expQ.size() != 0) begin
        popped = expQ.pop_front();
        checkOutput("sb_addr", W_ADDR, popped.addr);
        checkOutput("sb_pixel", PIXEL_OUT, popped.pix);
      end
    end
  end

  // Directed sequence
  initial begin
    int w0;
    int f0;
    RESET    = 1'b1;
    VSYNC    = 1'b0;
    HREF     = 1'b0;
    CAM_DATA = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("reset_pixel", PIXEL_OUT, 0);
    checkOutput("reset_addr", W_ADDR, 0);
    checkOutput("reset_wen", W_EN, 0);
    checkOutput("reset_frame_done", FRAME_DONE, 0);
    checkOutput("reset_line_count", LINE_COUNT, 0);

    // Release mid-frame: traffic before a VSYNC pulse must not be written
    RESET = 1'b0;
    w0 = writeCount;
    sendLine(0, 4, 1'b0, 1'b0);
    sendLine(1, 4, 1'b0, 1'b0);
    checkOutput("no_write_before_vsync", writeCount - w0, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("no_done_on_partial_frame", frameDoneCount, 0);
    startFrame();

    // Two-pixel line with explicit latency and hold checks
    applyStimulus(1'b0, 1'b1, 8'hE0);
    checkOutput("lat_first_byte_no_wen", W_EN, 0);
    pushExpected(0, 8'hE0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("lat_wen_px0", W_EN, 1);
    checkOutput("lat_addr_px0", W_ADDR, 0);
    checkOutput("lat_pixel_px0", PIXEL_OUT, 8'hE0);
    pushExpected(1, 8'h1F);
    applyStimulus(1'b0, 1'b1, 8'h07);
    checkOutput("wen_one_cycle", W_EN, 0);
    checkOutput("pixel_hold", PIXEL_OUT, 8'hE0);
    checkOutput("addr_hold", W_ADDR, 0);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("lat_wen_px1", W_EN, 1);
    checkOutput("lat_addr_px1", W_ADDR, 1);
    checkOutput("lat_pixel_px1", PIXEL_OUT, 8'h1F);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("line_end_no_wen", W_EN, 0);
    checkOutput("line_count_after_line", LINE_COUNT, 1);
    endFrame(1);
    checkOutput("two_px_drained", expQ.size(), 0);

    // Full 176x144 frame
    w0 = writeCount;
    f0 = frameDoneCount;
    startFrame();
    for (int y = 0; y < H; y++) sendLine(y, W, 1'b0, 1'b1);
    endFrame(144);
    checkOutput("full_write_count", writeCount - w0, 25344);
    checkOutput("full_last_addr", lastAddr, 25343);
    checkOutput("full_done_count", frameDoneCount - f0, 1);
    checkOutput("full_drained", expQ.size(), 0);

    // Oversized frame: 150 lines, three of them 200 pixels wide
    w0 = writeCount;
    startFrame();
    for (int y = 0; y < 150; y++)
      sendLine(y, (y == 0 || y == 143 || y == 145) ? 200 : 2, 1'b0, 1'b1);
    endFrame(150);
    checkOutput("over_write_count", writeCount - w0, 176 + 176 + 142 * 2);
    checkOutput("over_last_addr", lastAddr, 25343);
    checkOutput("over_drained", expQ.size(), 0);

    // Odd byte count line, next line must realign at address 176
    w0 = writeCount;
    startFrame();
    sendLine(0, 2, 1'b1, 1'b1);
    sendLine(1, 2, 1'b0, 1'b1);
    endFrame(2);
    checkOutput("odd_write_count", writeCount - w0, 4);
    checkOutput("odd_last_addr", lastAddr, 177);
    checkOutput("odd_drained", expQ.size(), 0);

    // VSYNC rising with a pending second byte; also a frame with no lines
    w0 = writeCount;
    startFrame();
    applyStimulus(1'b0, 1'b1, 8'hAB);
    applyStimulus(1'b1, 1'b1, 8'hCD);
    checkOutput("vs_mid_no_wen", W_EN, 0);
    checkOutput("vs_mid_done", FRAME_DONE, 1);
    checkOutput("vs_mid_zero_lines", LINE_COUNT, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("vs_mid_done_one_cycle", FRAME_DONE, 0);
    checkOutput("vs_mid_write_count", writeCount - w0, 0);

    // Asynchronous reset while a write strobe is high
    startFrame();
    applyStimulus(1'b0, 1'b1, 8'h12);
    applyStimulus(1'b0, 1'b1, 8'h34);
    checkOutput("pre_reset_wen", W_EN, 1);
    #1 RESET = 1'b1;
    #1;
    checkOutput("async_reset_wen", W_EN, 0);
    checkOutput("async_reset_addr", W_ADDR, 0);
    checkOutput("async_reset_pixel", PIXEL_OUT, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    RESET = 1'b0;
    w0 = writeCount;
    sendLine(0, 3, 1'b0, 1'b0);
    checkOutput("post_reset_no_write", writeCount - w0, 0);
    checkOutput("final_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
